wrapper_aes128: RTL and testbench

WRAPPER_AES128 -- requirements
Module: wrapper_aes128

---
 rtl/wrapper_aes128_pkg.sv | 126 ++++++++++++
 rtl/MSKaes_128bits_round_based.sv | 144 ++++++++++++++
 rtl/MSKcst.sv | 18 +
 rtl/prng_lfsr_bank.sv | 68 ++++++
 rtl/wrapper_aes128.sv | 92 +++++++++
 tb/tb_wrapper_aes128.sv | 344 ++++++++++++++++++++++++++++++++++
 6 files changed

// File: rtl/wrapper_aes128_pkg.sv
// Shared constants and AES GF(2^8) helpers for the wrapper_aes128 slice.
// CANRIGHT_SBOX_EN selects the alternate S-box inversion chain and enables rnd_bus3.
package wrapper_aes128_pkg;

    localparam int          LFSR_W       = 80;
    localparam int          LFSR_TAP_A   = 80;
    localparam int          LFSR_TAP_B   = 79;
    localparam int          LFSR_TAP_C   = 43;
    localparam int          LFSR_TAP_D   = 42;
    localparam int          WARMUP_STEPS = 160;
    localparam logic [15:0] SEED_SALT    = 16'hA5C3;

    typedef enum logic [0:0] {
        CORE_IDLE = 1'b0,
        CORE_BUSY = 1'b1
    } core_state_e;

    function automatic int rnd_bus0_w(input int d);
        return d * (d - 1) / 2;
    endfunction

    function automatic int rnd_bus1_w(input int d);
        return d * (d - 1) / 2;
    endfunction

    function automatic int rnd_bus2_w(input int d);
        return d * (d - 1);
    endfunction

    function automatic int rnd_bus3_w(input int d);
        return d * (d - 1) / 2;
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] a);
        return {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = 8'h00;
        x = a;
        for (int i = 0; i < 8; i++) begin
            p = p ^ (b[i] ? x : 8'h00);
            x = xtime(x);
        end
        return p;
    endfunction

    // Field inverse a^254, with 0 mapping to 0.
    function automatic logic [7:0] ginv(input logic [7:0] a);
        logic [7:0] r;
        logic [7:0] p;
`ifdef CANRIGHT_SBOX_EN
        r = a;
        for (int k = 0; k < 6; k++) begin
            r = gmul(gmul(r, r), a);
        end
        p = gmul(r, r);
        return p;
`else
        r = 8'h01;
        p = a;
        for (int k = 1; k < 8; k++) begin
            p = gmul(p, p);
            r = gmul(r, p);
        end
        return r;
`endif
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] b;
        b = ginv(a);
        return b ^ {b[6:0], b[7]} ^ {b[5:0], b[7:6]} ^ {b[4:0], b[7:5]} ^ {b[3:0], b[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [127:0] sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        for (int n = 0; n < 16; n++) begin
            o[8*n +: 8] = sbox(s[8*n +: 8]);
        end
        return o;
    endfunction

    // Byte 4*c+r holds row r of column c.
    function automatic logic [127:0] shift_rows(input logic [127:0] s);
        logic [127:0] o;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                o[8*(4*c+r) +: 8] = s[8*(4*((c+r)%4)+r) +: 8];
            end
        end
        return o;
    endfunction

    function automatic logic [127:0] mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        for (int c = 0; c < 4; c++) begin
            a0 = s[8*(4*c)   +: 8];
            a1 = s[8*(4*c+1) +: 8];
            a2 = s[8*(4*c+2) +: 8];
            a3 = s[8*(4*c+3) +: 8];
            o[8*(4*c)   +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            o[8*(4*c+1) +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            o[8*(4*c+2) +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            o[8*(4*c+3) +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return o;
    endfunction

    function automatic logic [127:0] next_key(input logic [127:0] k, input logic [7:0] rcon);
        logic [31:0] rot;
        logic [31:0] t;
        logic [31:0] n0, n1, n2, n3;
        rot = {k[103:96], k[127:104]};
        t   = {sbox(rot[31:24]), sbox(rot[23:16]), sbox(rot[15:8]), sbox(rot[7:0])} ^ {24'h000000, rcon};
        n0  = k[31:0] ^ t;
        n1  = k[63:32] ^ n0;
        n2  = k[95:64] ^ n1;
        n3  = k[127:96] ^ n2;
        return {n3, n2, n1, n0};
    endfunction

endpackage

// File: rtl/MSKaes_128bits_round_based.sv
// Round-based AES-128 core on Boolean-shared data; one round every LATENCY cycles.
// CANRIGHT_SBOX_EN adds the rnd_bus3w input. Output shares are refreshed from the randomness buses.
module MSKaes_128bits_round_based
    import wrapper_aes128_pkg::*;
#(
    parameter int d       = 2,
    parameter int LATENCY = 4
) (
    input  logic                         clk,
    input  logic                         nrst,
    input  logic                         valid_in,
    output logic                         in_ready,
    output logic                         cipher_valid,
    input  logic [128*d-1:0]             sh_plaintext,
    input  logic [128*d-1:0]             sh_key,
    output logic [128*d-1:0]             sh_ciphertext,
    input  logic [20*rnd_bus0_w(d)-1:0]  rnd_bus0w,
    input  logic [20*rnd_bus1_w(d)-1:0]  rnd_bus1w,
    input  logic [20*rnd_bus2_w(d)-1:0]  rnd_bus2w
`ifdef CANRIGHT_SBOX_EN
    ,
    input  logic [20*rnd_bus3_w(d)-1:0]  rnd_bus3w
`endif
);

`ifdef CANRIGHT_SBOX_EN
    localparam int RW = 20 * (rnd_bus0_w(d) + rnd_bus1_w(d) + rnd_bus2_w(d) + rnd_bus3_w(d));
`else
    localparam int RW = 20 * (rnd_bus0_w(d) + rnd_bus1_w(d) + rnd_bus2_w(d));
`endif
    localparam logic [7:0] WAIT_LAST = 8'(LATENCY - 1);

    logic [RW-1:0]      pool_s;
    logic [127:0]       pt_s, key_s;
    logic [127:0]       state_q, key_q;
    logic [127:0]       round_state_s, round_key_s;
    logic [128*d-1:0]   remask_s;
    logic [128*d-1:0]   sh_ct_q;
    logic               acc_s;
    logic [7:0]         rcon_q;
    logic [7:0]         wait_q;
    logic [3:0]         round_q;
    logic               in_ready_q;
    logic               cipher_valid_q;
    core_state_e        fsm_q;

`ifdef CANRIGHT_SBOX_EN
    assign pool_s = {rnd_bus3w, rnd_bus2w, rnd_bus1w, rnd_bus0w};
`else
    assign pool_s = {rnd_bus2w, rnd_bus1w, rnd_bus0w};
`endif

    assign in_ready      = in_ready_q;
    assign cipher_valid  = cipher_valid_q;
    assign sh_ciphertext = sh_ct_q;

    // Recombine the incoming shares.
    always_comb begin
        pt_s  = '0;
        key_s = '0;
        for (int i = 0; i < 128; i++) begin
            for (int j = 0; j < d; j++) begin
                pt_s[i]  = pt_s[i] ^ sh_plaintext[d*i+j];
                key_s[i] = key_s[i] ^ sh_key[d*i+j];
            end
        end
    end

    // One AES round plus key-schedule step; the final round skips MixColumns.
    always_comb begin
        round_key_s = next_key(key_q, rcon_q);
        if (round_q == 4'd10) begin
            round_state_s = shift_rows(sub_bytes(state_q)) ^ round_key_s;
        end else begin
            round_state_s = mix_columns(shift_rows(sub_bytes(state_q))) ^ round_key_s;
        end
    end

    // Re-share the round output: shares 1..d-1 from the pool, share 0 balances the XOR.
    always_comb begin
        remask_s = '0;
        acc_s    = 1'b0;
        for (int i = 0; i < 128; i++) begin
            acc_s = round_state_s[i];
            for (int j = 1; j < d; j++) begin
                remask_s[d*i+j] = pool_s[(i*(d-1)+j-1) % RW];
                acc_s           = acc_s ^ pool_s[(i*(d-1)+j-1) % RW];
            end
            remask_s[d*i] = acc_s;
        end
    end

    // Control FSM with datapath registers.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            fsm_q          <= CORE_IDLE;
            in_ready_q     <= 1'b1;
            cipher_valid_q <= 1'b0;
            sh_ct_q        <= '0;
            state_q        <= '0;
            key_q          <= '0;
            rcon_q         <= 8'h01;
            round_q        <= 4'd1;
            wait_q         <= 8'd0;
        end else begin
            case (fsm_q)
                CORE_IDLE: begin
                    if (valid_in) begin
                        state_q        <= pt_s ^ key_s;
                        key_q          <= key_s;
                        rcon_q         <= 8'h01;
                        round_q        <= 4'd1;
                        wait_q         <= WAIT_LAST;
                        in_ready_q     <= 1'b0;
                        cipher_valid_q <= 1'b0;
                        fsm_q          <= CORE_BUSY;
                    end
                end
                CORE_BUSY: begin
                    if (wait_q != 8'd0) begin
                        wait_q <= wait_q - 8'd1;
                    end else begin
                        state_q <= round_state_s;
                        key_q   <= round_key_s;
                        rcon_q  <= xtime(rcon_q);
                        round_q <= round_q + 4'd1;
                        wait_q  <= WAIT_LAST;
                        if (round_q == 4'd10) begin
                            sh_ct_q        <= remask_s;
                            cipher_valid_q <= 1'b1;
                            in_ready_q     <= 1'b1;
                            fsm_q          <= CORE_IDLE;
                        end
                    end
                end
                default: begin
                    fsm_q      <= CORE_IDLE;
                    in_ready_q <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: rtl/MSKcst.sv
// Constant-sharing cell: share 0 of each bit carries the constant, other shares are zero.
module MSKcst #(
    parameter int d     = 2,
    parameter int count = 1
) (
    input  logic [count-1:0]   cst,
    output logic [count*d-1:0] out
);

    // Place each constant bit in share 0 of its group.
    always_comb begin
        out = '0;
        for (int i = 0; i < count; i++) begin
            out[d*i] = cst[i];
        end
    end

endmodule

// File: rtl/prng_lfsr_bank.sv
// Bank of 80-bit Fibonacci LFSRs (taps 80,79,43,42) with seeded reseed and warm-up.
module prng_lfsr_bank
    import wrapper_aes128_pkg::*;
#(
    parameter int R = 80
) (
    input  logic         clk,
    input  logic         nrst,
    input  logic [79:0]  seed_i,
    input  logic         start_reseed_i,
    input  logic         out_ready_i,
    output logic         out_valid_o,
    output logic [R-1:0] rnd_o
);

    localparam int NLFSR = (R + LFSR_W - 1) / LFSR_W;

    logic [LFSR_W*NLFSR-1:0] state_q;
    logic [LFSR_W*NLFSR-1:0] state_d;
    logic [LFSR_W-1:0]       cur_s;
    logic                    fb_s;
    logic [7:0]              warm_q;
    logic                    valid_q;
    logic                    step_s;

    assign step_s      = (warm_q != 8'd0) | (valid_q & out_ready_i);
    assign out_valid_o = valid_q;
    assign rnd_o       = state_q[R-1:0];

    // Per-LFSR next state: reseed load, shift, or hold.
    always_comb begin
        state_d = state_q;
        cur_s   = '0;
        fb_s    = 1'b0;
        for (int k = 0; k < NLFSR; k++) begin
            cur_s = state_q[LFSR_W*k +: LFSR_W];
            fb_s  = cur_s[LFSR_TAP_A-1] ^ cur_s[LFSR_TAP_B-1] ^ cur_s[LFSR_TAP_C-1] ^ cur_s[LFSR_TAP_D-1];
            if (start_reseed_i) begin
                state_d[LFSR_W*k +: LFSR_W] = seed_i ^ {SEED_SALT, 64'(k + 1)};
            end else if (step_s) begin
                state_d[LFSR_W*k +: LFSR_W] = {cur_s[LFSR_W-2:0], fb_s};
            end else begin
                state_d[LFSR_W*k +: LFSR_W] = cur_s;
            end
        end
    end

    // State register and warm-up countdown gating out_valid.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q <= '0;
            warm_q  <= 8'd0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (start_reseed_i) begin
                warm_q  <= 8'(WARMUP_STEPS);
                valid_q <= 1'b0;
            end else if (warm_q != 8'd0) begin
                warm_q  <= warm_q - 8'd1;
                valid_q <= (warm_q == 8'd1);
            end else begin
                valid_q <= valid_q;
            end
        end
    end

endmodule

// File: rtl/wrapper_aes128.sv
// Masked AES-128 wrapper: LFSR-bank randomness, reseed sequencing and handshake gating.
// Define CANRIGHT_SBOX_EN to build the core with rnd_bus3w included in the PRNG word.
module wrapper_aes128
    import wrapper_aes128_pkg::*;
#(
    parameter int d       = 2,
    parameter int LATENCY = 4
) (
    input  logic             clk,
    input  logic             nrst,
    input  logic             valid_in,
    output logic             ready,
    output logic             cipher_valid,
    input  logic [128*d-1:0] sh_plaintext,
    input  logic [128*d-1:0] sh_key,
    output logic [128*d-1:0] sh_ciphertext,
    input  logic [79:0]      prng_seed,
    input  logic             prng_start_reseed,
    input  logic             prng_out_ready,
    output logic             prng_out_valid
);

    localparam int W0 = 20 * rnd_bus0_w(d);
    localparam int W1 = 20 * rnd_bus1_w(d);
    localparam int W2 = 20 * rnd_bus2_w(d);
`ifdef CANRIGHT_SBOX_EN
    localparam int W3 = 20 * rnd_bus3_w(d);
    localparam int R  = W0 + W1 + W2 + W3;
`else
    localparam int R  = W0 + W1 + W2;
`endif

    logic [R-1:0] rnd_s;
    logic         core_ready_s;
    logic         core_valid_s;
    logic         prng_valid_s;
    logic         reseed_go_s;
    logic         reseed_pend_q;

    // A reseed may only start while the core is idle; otherwise it waits in reseed_pend_q.
    assign reseed_go_s    = (prng_start_reseed | reseed_pend_q) & core_ready_s;
    assign ready          = core_ready_s & prng_valid_s & ~reseed_pend_q;
    assign core_valid_s   = valid_in & ready & ~prng_start_reseed;
    assign prng_out_valid = prng_valid_s;

    // Deferred reseed request.
    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            reseed_pend_q <= 1'b0;
        end else if (reseed_go_s) begin
            reseed_pend_q <= 1'b0;
        end else if (prng_start_reseed) begin
            reseed_pend_q <= 1'b1;
        end else begin
            reseed_pend_q <= reseed_pend_q;
        end
    end

    prng_lfsr_bank #(
        .R (R)
    ) u_prng (
        .clk            (clk),
        .nrst           (nrst),
        .seed_i         (prng_seed),
        .start_reseed_i (reseed_go_s),
        .out_ready_i    (prng_out_ready),
        .out_valid_o    (prng_valid_s),
        .rnd_o          (rnd_s)
    );

    MSKaes_128bits_round_based #(
        .d       (d),
        .LATENCY (LATENCY)
    ) u_core (
        .clk           (clk),
        .nrst          (nrst),
        .valid_in      (core_valid_s),
        .in_ready      (core_ready_s),
        .cipher_valid  (cipher_valid),
        .sh_plaintext  (sh_plaintext),
        .sh_key        (sh_key),
        .sh_ciphertext (sh_ciphertext),
        .rnd_bus0w     (rnd_s[W0-1:0]),
        .rnd_bus1w     (rnd_s[W0 +: W1]),
        .rnd_bus2w     (rnd_s[W0+W1 +: W2])
`ifdef CANRIGHT_SBOX_EN
        ,
        .rnd_bus3w     (rnd_s[W0+W1+W2 +: W3])
`endif
    );

endmodule

// File: tb/tb_wrapper_aes128.sv
// Directed self-checking bench for wrapper_aes128 (d=3) using the FIPS-197 Appendix B vector.
module tb_wrapper_aes128;

    localparam int          D   = 3;
    localparam int          LAT = 4;
    localparam logic [127:0] KEY = 128'h3c4fcf098815f7aba6d2ae2816157e2b;
    localparam logic [127:0] PT  = 128'h340737e0a29831318d305a88a8f64332;
    localparam logic [127:0] CT  = 128'h320b6a19978511dcfb09dc021d842539;

    logic             clk = 1'b0;
    logic             nrst;
    logic             valid_in;
    logic             ready;
    logic             cipher_valid;
    logic [128*D-1:0] sh_plaintext;
    logic [128*D-1:0] sh_key;
    logic [128*D-1:0] sh_ciphertext;
    logic [79:0]      prng_seed;
    logic             prng_start_reseed;
    logic             prng_out_ready;
    logic             prng_out_valid;

    logic [127:0]     key_v;
    logic [127:0]     pt_v;
    logic [128*D-1:0] cst_key_s;
    logic [128*D-1:0] cst_pt_s;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    wrapper_aes128 #(.d(D), .LATENCY(LAT)) dut (
        .clk               (clk),
        .nrst              (nrst),
        .valid_in          (valid_in),
        .ready             (ready),
        .cipher_valid      (cipher_valid),
        .sh_plaintext      (sh_plaintext),
        .sh_key            (sh_key),
        .sh_ciphertext     (sh_ciphertext),
        .prng_seed         (prng_seed),
        .prng_start_reseed (prng_start_reseed),
        .prng_out_ready    (prng_out_ready),
        .prng_out_valid    (prng_out_valid)
    );

    MSKcst #(.d(D), .count(128)) u_cst_key (.cst(key_v), .out(cst_key_s));
    MSKcst #(.d(D), .count(128)) u_cst_pt  (.cst(pt_v),  .out(cst_pt_s));

    function automatic logic [127:0] unmask(input logic [128*D-1:0] sh);
        logic [127:0] v;
        v = '0;
        for (int i = 0; i < 128; i++) begin
            for (int j = 0; j < D; j++) begin
                v[i] = v[i] ^ sh[D*i+j];
            end
        end
        return v;
    endfunction

    function automatic logic [128*D-1:0] share_rand(input logic [127:0] v);
        logic [128*D-1:0] sh;
        logic             acc;
        logic             r;
        for (int i = 0; i < 128; i++) begin
            acc = v[i];
            for (int j = 1; j < D; j++) begin
                r = 1'($urandom_range(0, 1));
                sh[D*i+j] = r;
                acc = acc ^ r;
            end
            sh[D*i] = acc;
        end
        return sh;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reseed and wait (bounded) for the PRNG to come up.
    task automatic reseed(input logic [79:0] seed);
        int n;
        prng_seed = seed;
        prng_start_reseed = 1'b1;
        tick();
        prng_start_reseed = 1'b0;
        n = 0;
        while (!prng_out_valid && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (prng_out_valid !== 1'b1) begin
            n_fail++;
            $display("FAIL reseed_done: prng_out_valid=%b expected 1", prng_out_valid);
        end
    endtask

    // Pulse valid_in and wait (bounded) for cipher_valid.
    task automatic run_encrypt(output logic cv_after, output int cyc);
        int n;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        cv_after = cipher_valid;
        n = 0;
        while (!cipher_valid && n < 300) begin
            tick();
            n++;
        end
        cyc = n;
    endtask

    task automatic test_reset();
        nrst = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL reset_ready: got %b expected 0", ready); end
        n_checks++;
        if (cipher_valid !== 1'b0) begin n_fail++; $display("FAIL reset_cipher_valid: got %b expected 0", cipher_valid); end
        n_checks++;
        if (prng_out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_prng_valid: got %b expected 0", prng_out_valid); end
        n_checks++;
        if (sh_ciphertext !== '0) begin n_fail++; $display("FAIL reset_ciphertext: got %h expected 0", sh_ciphertext); end
        nrst = 1'b1;
        tick();
    endtask

    task automatic test_no_reseed();
        int highs;
        sh_key       = cst_key_s;
        sh_plaintext = cst_pt_s;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        highs = 0;
        for (int n = 0; n < 60; n++) begin
            if (cipher_valid !== 1'b0) highs++;
            tick();
        end
        n_checks++;
        if (highs != 0) begin n_fail++; $display("FAIL no_reseed_ignored: cipher_valid high %0d cycles expected 0", highs); end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL no_reseed_ready: got %b expected 0", ready); end
    endtask

    task automatic test_reseed_timing();
        int bad;
        prng_seed = 80'h0;
        prng_start_reseed = 1'b1;
        tick();
        prng_start_reseed = 1'b0;
        bad = 0;
        for (int n = 0; n < 160; n++) begin
            if (prng_out_valid !== 1'b0 || ready !== 1'b0) bad++;
            tick();
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL warmup_low: %0d of 160 cycles valid/ready high, expected 0", bad); end
        n_checks++;
        if (prng_out_valid !== 1'b1) begin n_fail++; $display("FAIL warmup_rise: prng_out_valid=%b expected 1", prng_out_valid); end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL warmup_ready: ready=%b expected 1", ready); end
    endtask

    task automatic test_encrypt_const();
        logic cv_after;
        int   cyc;
        sh_key       = cst_key_s;
        sh_plaintext = cst_pt_s;
        run_encrypt(cv_after, cyc);
        n_checks++;
        if (cv_after !== 1'b0) begin n_fail++; $display("FAIL const_busy: cipher_valid=%b expected 0", cv_after); end
        n_checks++;
        if (cipher_valid !== 1'b1) begin n_fail++; $display("FAIL const_done: cipher_valid=%b after %0d cycles expected 1", cipher_valid, cyc); end
        n_checks++;
        if (unmask(sh_ciphertext) !== CT) begin n_fail++; $display("FAIL const_ct: got %h expected %h", unmask(sh_ciphertext), CT); end
        repeat (5) tick();
        n_checks++;
        if (cipher_valid !== 1'b1 || unmask(sh_ciphertext) !== CT) begin
            n_fail++; $display("FAIL const_hold: cipher_valid=%b ct=%h expected 1 %h", cipher_valid, unmask(sh_ciphertext), CT);
        end
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL const_ready: got %b expected 1", ready); end
    endtask

    task automatic test_random_shares();
        logic cv_after;
        int   cyc;
        reseed(80'h0123_4567_89AB_CDEF_1357);
        sh_key       = share_rand(KEY);
        sh_plaintext = share_rand(PT);
        run_encrypt(cv_after, cyc);
        n_checks++;
        if (cv_after !== 1'b0) begin n_fail++; $display("FAIL rand_busy: cipher_valid=%b expected 0", cv_after); end
        n_checks++;
        if (cipher_valid !== 1'b1) begin n_fail++; $display("FAIL rand_done: cipher_valid=%b after %0d cycles expected 1", cipher_valid, cyc); end
        n_checks++;
        if (unmask(sh_ciphertext) !== CT) begin n_fail++; $display("FAIL rand_ct: got %h expected %h", unmask(sh_ciphertext), CT); end
    endtask

    task automatic test_back_to_back();
        logic cv_after;
        int   cyc;
        sh_key       = share_rand(KEY);
        sh_plaintext = share_rand(PT);
        run_encrypt(cv_after, cyc);
        n_checks++;
        if (cv_after !== 1'b0) begin n_fail++; $display("FAIL b2b_busy: cipher_valid=%b expected 0", cv_after); end
        n_checks++;
        if (unmask(sh_ciphertext) !== CT) begin n_fail++; $display("FAIL b2b_ct: got %h expected %h", unmask(sh_ciphertext), CT); end
    endtask

    task automatic test_reseed_defer();
        int bad;
        int n;
        sh_key       = share_rand(KEY);
        sh_plaintext = share_rand(PT);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (5) tick();
        prng_start_reseed = 1'b1;
        tick();
        prng_start_reseed = 1'b0;
        bad = 0;
        n = 0;
        while (!cipher_valid && n < 300) begin
            if (ready !== 1'b0 || prng_out_valid !== 1'b1) bad++;
            tick();
            n++;
        end
        n_checks++;
        if (bad != 0) begin n_fail++; $display("FAIL defer_busy: %0d cycles with ready=1 or prng invalid, expected 0", bad); end
        n_checks++;
        if (cipher_valid !== 1'b1 || unmask(sh_ciphertext) !== CT) begin
            n_fail++; $display("FAIL defer_ct: cipher_valid=%b ct=%h expected 1 %h", cipher_valid, unmask(sh_ciphertext), CT);
        end
        n_checks++;
        if (ready !== 1'b0) begin n_fail++; $display("FAIL defer_ready: got %b expected 0", ready); end
        tick();
        n_checks++;
        if (prng_out_valid !== 1'b0) begin n_fail++; $display("FAIL defer_start: prng_out_valid=%b expected 0", prng_out_valid); end
        n = 0;
        while (!prng_out_valid && n < 400) begin
            tick();
            n++;
        end
        n_checks++;
        if (n != 160) begin n_fail++; $display("FAIL defer_warmup: %0d cycles expected 160", n); end
    endtask

    task automatic test_simultaneous();
        valid_in = 1'b1;
        prng_start_reseed = 1'b1;
        tick();
        valid_in = 1'b0;
        prng_start_reseed = 1'b0;
        n_checks++;
        if (cipher_valid !== 1'b1) begin n_fail++; $display("FAIL simul_dropped: cipher_valid=%b expected 1", cipher_valid); end
        n_checks++;
        if (prng_out_valid !== 1'b0) begin n_fail++; $display("FAIL simul_reseed: prng_out_valid=%b expected 0", prng_out_valid); end
        repeat (3) tick();
        sh_plaintext = share_rand(128'h0);
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        tick();
        n_checks++;
        if (cipher_valid !== 1'b1 || unmask(sh_ciphertext) !== CT) begin
            n_fail++; $display("FAIL warmup_ignore: cipher_valid=%b ct=%h expected 1 %h", cipher_valid, unmask(sh_ciphertext), CT);
        end
        for (int n = 0; n < 400 && !prng_out_valid; n++) tick();
        n_checks++;
        if (ready !== 1'b1) begin n_fail++; $display("FAIL simul_ready: got %b expected 1", ready); end
    endtask

    task automatic test_reset_mid_run();
        logic cv_after;
        int   cyc;
        int   highs;
        sh_key       = cst_key_s;
        sh_plaintext = cst_pt_s;
        valid_in = 1'b1;
        tick();
        valid_in = 1'b0;
        repeat (10) tick();
        #2;
        nrst = 1'b0;
        #1;
        n_checks++;
        if (cipher_valid !== 1'b0 || ready !== 1'b0 || prng_out_valid !== 1'b0) begin
            n_fail++; $display("FAIL midrst_flags: cv=%b ready=%b pv=%b expected 0 0 0", cipher_valid, ready, prng_out_valid);
        end
        n_checks++;
        if (sh_ciphertext !== '0) begin n_fail++; $display("FAIL midrst_ct: got %h expected 0", sh_ciphertext); end
        repeat (2) tick();
        nrst = 1'b1;
        tick();
        highs = 0;
        for (int n = 0; n < 60; n++) begin
            if (cipher_valid !== 1'b0) highs++;
            tick();
        end
        n_checks++;
        if (highs != 0) begin n_fail++; $display("FAIL midrst_abort: cipher_valid high %0d cycles expected 0", highs); end
        reseed(80'hFEDC_BA98_7654_3210_0F0F);
        run_encrypt(cv_after, cyc);
        n_checks++;
        if (cv_after !== 1'b0) begin n_fail++; $display("FAIL rerun_busy: cipher_valid=%b expected 0", cv_after); end
        n_checks++;
        if (cipher_valid !== 1'b1 || unmask(sh_ciphertext) !== CT) begin
            n_fail++; $display("FAIL rerun_ct: cipher_valid=%b ct=%h expected 1 %h", cipher_valid, unmask(sh_ciphertext), CT);
        end
    endtask

    initial begin
        nrst              = 1'b0;
        valid_in          = 1'b0;
        prng_start_reseed = 1'b0;
        prng_out_ready    = 1'b1;
        prng_seed         = 80'h0;
        key_v             = KEY;
        pt_v              = PT;
        sh_key            = '0;
        sh_plaintext      = '0;
        test_reset();
        test_no_reseed();
        test_reseed_timing();
        test_encrypt_const();
        test_random_shares();
        test_back_to_back();
        test_reseed_defer();
        test_simultaneous();
        test_reset_mid_run();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
